// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch / program-load sequencer in front of a 4096 x 29 instruction RAM.
// Fetch: fetch_req sampled in IDLE -> ir_valid three cycles later. Load: one write cycle, then ld_ack.
module instr_fetch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [11:0] pc_load_val,
    input  logic        ld_req,
    input  logic [11:0] ld_addr,
    input  logic [28:0] ld_data,
    input  logic [28:0] ram_rdata,
    output logic [11:0] pc,
    output logic [28:0] ir,
    output logic        ir_valid,
    output logic        ld_ack,
    output logic        busy,
    output logic [11:0] ram_address,
    output logic        ram_read_not_write,
    output logic [28:0] ram_wdata,
    output logic        ram_wdata_en
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        DONE,
        WR,
        WACK
    } state_t;

    state_t      state;
    logic [11:0] pc_next;
    logic        start_wr;

    // A branch load always beats the post-capture increment.
    always_comb begin
        pc_next = pc;
        if (pc_load) begin
            pc_next = pc_load_val;
        end else if (state == CAP) begin
            pc_next = pc + 12'd1;
        end
    end

    assign start_wr = (state == IDLE) && ld_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= IDLE;
            pc                 <= 12'd0;
            ir                 <= 29'd0;
            ir_valid           <= 1'b0;
            ld_ack             <= 1'b0;
            busy               <= 1'b0;
            ram_address        <= 12'd0;
            ram_read_not_write <= 1'b1;
            ram_wdata          <= 29'd0;
            ram_wdata_en       <= 1'b0;
        end else begin
            ir_valid           <= 1'b0;
            ld_ack             <= 1'b0;
            ram_read_not_write <= 1'b1;
            ram_wdata_en       <= 1'b0;
            pc                 <= pc_next;
            // The address bus follows pc everywhere except the write cycle.
            ram_address        <= start_wr ? ld_addr : pc_next;

            case (state)
                IDLE: begin
                    if (ld_req) begin
                        state              <= WR;
                        busy               <= 1'b1;
                        ram_wdata          <= ld_data;
                        ram_read_not_write <= 1'b0;
                        ram_wdata_en       <= 1'b1;
                    end else if (fetch_req) begin
                        state <= RD;
                        busy  <= 1'b1;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    ir       <= ram_rdata;
                    ir_valid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                WR: begin
                    ld_ack <= 1'b1;
                    state  <= WACK;
                end
                WACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: transaction-level model (expected memory image, pc, ir)
// driven by directed corner cases followed by a randomized operation mix.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic        pc_load;
    logic [11:0] pc_load_val;
    logic        ld_req;
    logic [11:0] ld_addr;
    logic [28:0] ld_data;
    logic [28:0] ram_rdata;
    logic [11:0] pc;
    logic [28:0] ir;
    logic        ir_valid;
    logic        ld_ack;
    logic        busy;
    logic [11:0] ram_address;
    logic        ram_read_not_write;
    logic [28:0] ram_wdata;
    logic        ram_wdata_en;

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_req          (fetch_req),
        .pc_load            (pc_load),
        .pc_load_val        (pc_load_val),
        .ld_req             (ld_req),
        .ld_addr            (ld_addr),
        .ld_data            (ld_data),
        .ram_rdata          (ram_rdata),
        .pc                 (pc),
        .ir                 (ir),
        .ir_valid           (ir_valid),
        .ld_ack             (ld_ack),
        .busy               (busy),
        .ram_address        (ram_address),
        .ram_read_not_write (ram_read_not_write),
        .ram_wdata          (ram_wdata),
        .ram_wdata_en       (ram_wdata_en)
    );

    function automatic logic [28:0] fill(input int a);
        return 29'((a * 32'h9E3779B1) ^ 32'h0155AA33);
    endfunction

    // Synchronous RAM: read data one cycle after the address, write on a strobed edge.
    logic [28:0] ram     [4096];
    bit          ram_wr  [4096];
    always @(posedge clk) begin
        ram_rdata <= ram_wr[ram_address] ? ram[ram_address] : fill(int'(ram_address));
        if (!ram_read_not_write && ram_wdata_en) begin
            ram[ram_address]    <= ram_wdata;
            ram_wr[ram_address] <= 1'b1;
        end
    end

    // Reference model state.
    logic [28:0] exp_mem [4096];
    logic [11:0] m_pc;
    logic [28:0] m_ir;
    int errs = 0;
    int checks = 0;
    int n_valid = 0;
    int n_ack = 0;
    int exp_valid = 0;
    int exp_ack = 0;

    always @(negedge clk) begin
        if (ir_valid) n_valid++;
        if (ld_ack) n_ack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_idle_checks(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_ir"}, ir, 0);
        check({tag, "_ir_valid"}, ir_valid, 0);
        check({tag, "_ld_ack"}, ld_ack, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rnw"}, ram_read_not_write, 1);
        check({tag, "_wen"}, ram_wdata_en, 0);
    endtask

    task automatic do_load(input logic [11:0] a, input logic [28:0] d);
        ld_req  = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        check("wr_rnw", ram_read_not_write, 0);
        check("wr_en", ram_wdata_en, 1);
        check("wr_addr", ram_address, a);
        check("wr_data", ram_wdata, d);
        check("wr_busy", busy, 1);
        check("wr_ack_early", ld_ack, 0);
        tick();
        check("wack_ack", ld_ack, 1);
        check("wack_en", ram_wdata_en, 0);
        ld_req = 1'b0;
        tick();
        check("ld_ack_pulse", ld_ack, 0);
        check("ld_busy_end", busy, 0);
        check("ld_pc_kept", pc, m_pc);
        check("ld_ir_kept", ir, m_ir);
        exp_mem[a] = d;
        exp_ack++;
    endtask

    task automatic do_pcload(input logic [11:0] tgt);
        pc_load     = 1'b1;
        pc_load_val = tgt;
        tick();
        pc_load = 1'b0;
        check("pcload_pc", pc, tgt);
        check("pcload_busy", busy, 0);
        m_pc = tgt;
    endtask

    // Fetch from the model pc; optionally strobe a branch onto the CAP edge.
    task automatic do_fetch(input bit br, input logic [11:0] tgt);
        int lat;
        logic [11:0] a;
        lat = 0;
        a = m_pc;
        fetch_req = 1'b1;
        while (lat < 10) begin
            tick();
            pc_load = 1'b0;
            lat++;
            if (lat == 1) begin
                check("rd_addr", ram_address, a);
                check("rd_rnw", ram_read_not_write, 1);
                check("rd_busy", busy, 1);
            end
            if (ir_valid) break;
            if (br && lat == 2) begin
                pc_load     = 1'b1;
                pc_load_val = tgt;
            end
        end
        fetch_req = 1'b0;
        check("fetch_latency", lat, 3);
        check("fetch_ir", ir, exp_mem[a]);
        m_pc = br ? tgt : a + 12'd1;
        m_ir = exp_mem[a];
        check("fetch_pc", pc, m_pc);
        exp_valid++;
        tick();
        check("ir_valid_pulse", ir_valid, 0);
        check("fetch_busy_end", busy, 0);
    endtask

    // Load and fetch presented together; the load must go first, then the fetch reads it.
    task automatic do_both(input logic [28:0] d);
        int lat;
        logic [11:0] a;
        a = m_pc;
        lat = 0;
        ld_req = 1'b1;
        ld_addr = a;
        ld_data = d;
        fetch_req = 1'b1;
        tick();
        check("both_wr_first", ram_read_not_write, 0);
        check("both_ir_valid", ir_valid, 0);
        tick();
        check("both_ack", ld_ack, 1);
        ld_req = 1'b0;
        while (lat < 10) begin
            tick();
            lat++;
            if (ir_valid) break;
        end
        fetch_req = 1'b0;
        exp_mem[a] = d;
        check("both_fetch_lat", lat, 4);
        check("both_ir", ir, d);
        m_pc = a + 12'd1;
        m_ir = d;
        check("both_pc", pc, m_pc);
        exp_ack++;
        exp_valid++;
        tick();
    endtask

    task automatic do_stream();
        int cnt;
        logic [11:0] mpc;
        cnt = 0;
        mpc = m_pc;
        fetch_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ir_valid) begin
                cnt++;
                check("stream_ir", ir, exp_mem[mpc]);
                m_ir = exp_mem[mpc];
                mpc = mpc + 12'd1;
            end
        end
        fetch_req = 1'b0;
        tick();
        check("stream_pulses", cnt, 3);
        check("stream_pc", pc, m_pc + 12'd3);
        m_pc = m_pc + 12'd3;
        exp_valid += 3;
    endtask

    task automatic do_reset_in_wr(input logic [11:0] a, input logic [28:0] d);
        ld_req  = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        check("rstwr_in_wr", ram_wdata_en, 1);
        rst_n = 1'b0;
        fetch_req = 1'b1;
        tick();
        do_reset_idle_checks("rstwr");
        tick();
        check("rstwr_ignore_req", busy, 0);
        ld_req = 1'b0;
        fetch_req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rstwr_no_ack", ld_ack, 0);
        check("rstwr_idle", busy, 0);
        // The write strobe was on the bus for its whole cycle before reset hit.
        exp_mem[a] = d;
        m_pc = 12'd0;
        m_ir = 29'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) exp_mem[i] = fill(i);
        rst_n       = 1'b0;
        fetch_req   = 1'b1;
        ld_req      = 1'b1;
        pc_load     = 1'b0;
        pc_load_val = 12'd0;
        ld_addr     = 12'h005;
        ld_data     = 29'h0;
        tick();
        tick();
        do_reset_idle_checks("reset");
        check("reset_wdata", ram_wdata, 0);
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        rst_n     = 1'b1;
        tick();
        m_pc = 12'd0;
        m_ir = 29'd0;

        do_load(12'h800, 29'h1ABCDEF0);
        do_pcload(12'h800);
        do_fetch(1'b0, 12'd0);
        check("load_fetch_pc", pc, 12'h801);

        do_both(29'h0F0F0F0);

        do_pcload(12'hFFF);
        do_fetch(1'b0, 12'd0);
        check("wrap_pc", pc, 12'h000);

        do_pcload(12'h010);
        do_fetch(1'b1, 12'h123);
        check("branch_at_cap_pc", pc, 12'h123);

        do_stream();
        do_reset_in_wr(12'h3C4, 29'h1234567);

        for (int i = 0; i < 60; i++) begin
            logic [28:0] d;
            logic [11:0] a;
            d = 29'($urandom);
            a = ($urandom_range(0, 1) == 0) ? m_pc : 12'($urandom);
            case ($urandom_range(0, 4))
                0: do_load(a, d);
                1: do_fetch(1'b0, 12'd0);
                2: do_pcload(12'($urandom));
                3: do_both(d);
                default: do_fetch(1'b1, 12'($urandom));
            endcase
        end

        tick();
        check("total_ir_valid", n_valid, exp_valid);
        check("total_ld_ack", n_ack, exp_ack);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
